// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing, index types and the modulo-DEPTH pointer helper for the
// physical register free list.
package phys_reg_free_list_pkg;

   localparam int NUM_PHYS_REGS   = 128;
   localparam int NUM_ARCH_REGS   = 32;
   localparam int ALLOC_WIDTH     = 2;
   localparam int FREE_WIDTH      = 2;

   localparam int PHYS_IDX_BITS   = $clog2(NUM_PHYS_REGS);
   localparam int FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
   localparam int PTR_BITS        = $clog2(FREE_LIST_DEPTH);
   localparam int COUNT_BITS      = $clog2(FREE_LIST_DEPTH + 1);
   localparam int ALLOC_CW        = $clog2(ALLOC_WIDTH + 1);
   localparam int FREE_CW         = $clog2(FREE_WIDTH + 1);

   typedef logic [PHYS_IDX_BITS-1:0] phys_idx_t;
   typedef logic [PTR_BITS-1:0]      ptr_t;
   typedef logic [COUNT_BITS-1:0]    count_t;

   localparam logic [PTR_BITS:0] DEPTH_PTR = FREE_LIST_DEPTH[PTR_BITS:0];

   // DEPTH is not a power of two, so wrap by explicit compare-and-subtract.
   function automatic ptr_t ptr_add(input ptr_t p, input ptr_t k);
      logic [PTR_BITS:0] s;
      s = {1'b0, p} + {1'b0, k};
      if (s >= DEPTH_PTR) s = s - DEPTH_PTR;
      return s[PTR_BITS-1:0];
   endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/retire side bus of the free list. Allocation is all-or-nothing: the
// requested lanes are served in the same cycle only while alloc_grant_out is 1.
interface phys_reg_free_list_if;
   import phys_reg_free_list_pkg::*;

   logic [ALLOC_WIDTH-1:0]            alloc_req_in;
   logic                              alloc_grant_out;
   phys_idx_t [ALLOC_WIDTH-1:0]       alloc_idx_out;
   logic [FREE_WIDTH-1:0]             free_en_in;
   phys_idx_t [FREE_WIDTH-1:0]        free_idx_in;
   count_t                            count_out;
   logic                              empty_out;
   logic                              overflow_err_out;

   modport master (
      output alloc_req_in, free_en_in, free_idx_in,
      input  alloc_grant_out, alloc_idx_out, count_out, empty_out, overflow_err_out
   );

   modport slave (
      input  alloc_req_in, free_en_in, free_idx_in,
      output alloc_grant_out, alloc_idx_out, count_out, empty_out, overflow_err_out
   );

endinterface

// File: rtl/phys_reg_free_list_popcount_compact.sv
// Lane popcount plus, per lane, the number of set lanes below it; the latter is
// the compacted slot offset a set lane uses.
module popcount_compact #(
   parameter int W  = 2,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]         bits,
   output logic [CW-1:0]        total,
   output logic [W-1:0][CW-1:0] offset
);

   always_comb begin
      logic [CW-1:0] run;
      run = '0;
      for (int l = 0; l < W; l++) begin
         offset[l] = run;
         run       = run + CW'(bits[l]);
      end
      total = run;
   end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register indices: rename pops up to
// ALLOC_WIDTH per cycle, retire pushes up to FREE_WIDTH per cycle.
module phys_reg_free_list
   import phys_reg_free_list_pkg::*;
(
   input logic                  clk_in,
   input logic                  rst_in,
   phys_reg_free_list_if.slave  bus
);

   localparam logic [COUNT_BITS:0] DEPTH_SUM = (COUNT_BITS + 1)'(FREE_LIST_DEPTH);
   localparam count_t              DEPTH_CNT = COUNT_BITS'(FREE_LIST_DEPTH);

   phys_idx_t entries [FREE_LIST_DEPTH];
   ptr_t      head;
   ptr_t      tail;
   count_t    count;
   logic      overflow_err;

   logic [ALLOC_CW-1:0]                  n_req;
   logic [ALLOC_WIDTH-1:0][ALLOC_CW-1:0] alloc_off;
   logic [FREE_CW-1:0]                   n_free;
   logic [FREE_WIDTH-1:0][FREE_CW-1:0]   free_off;

   popcount_compact #(.W(ALLOC_WIDTH), .CW(ALLOC_CW)) u_alloc_pc (
      .bits   (bus.alloc_req_in),
      .total  (n_req),
      .offset (alloc_off)
   );

   popcount_compact #(.W(FREE_WIDTH), .CW(FREE_CW)) u_free_pc (
      .bits   (bus.free_en_in),
      .total  (n_free),
      .offset (free_off)
   );

   logic                    grant;
   count_t                  n_granted;
   count_t                  count_after_alloc;
   logic [COUNT_BITS:0]     count_sum;
   logic                    overflow_now;
   count_t                  count_next;
   phys_idx_t [ALLOC_WIDTH-1:0] alloc_idx;

   // Grant looks only at the current count; same-cycle frees never help.
   always_comb begin
      grant             = count_t'(n_req) <= count;
      n_granted         = grant ? count_t'(n_req) : '0;
      count_after_alloc = count - n_granted;
      count_sum         = {1'b0, count_after_alloc} + {1'b0, count_t'(n_free)};
      overflow_now      = count_sum > DEPTH_SUM;
      count_next        = overflow_now ? count_after_alloc : count_sum[COUNT_BITS-1:0];
   end

   always_comb begin
      for (int l = 0; l < ALLOC_WIDTH; l++) begin
         alloc_idx[l] = entries[ptr_add(head, ptr_t'(alloc_off[l]))];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
            entries[i] <= phys_idx_t'(NUM_ARCH_REGS + i);
         end
         head         <= '0;
         tail         <= '0;
         count        <= DEPTH_CNT;
         overflow_err <= 1'b0;
      end else begin
         if (grant) head <= ptr_add(head, ptr_t'(n_req));
         // An overflowing free batch is dropped whole; allocation is unaffected.
         if (!overflow_now) begin
            for (int l = 0; l < FREE_WIDTH; l++) begin
               if (bus.free_en_in[l]) begin
                  entries[ptr_add(tail, ptr_t'(free_off[l]))] <= bus.free_idx_in[l];
               end
            end
            tail <= ptr_add(tail, ptr_t'(n_free));
         end else begin
            overflow_err <= 1'b1;
         end
         count <= count_next;
      end
   end

   assign bus.alloc_grant_out  = grant;
   assign bus.alloc_idx_out    = alloc_idx;
   assign bus.count_out        = count;
   assign bus.empty_out        = (count == '0);
   assign bus.overflow_err_out = overflow_err;

endmodule
